// File: rtl/change_req_gen.sv
// Button-driven change-request initiator: synchronize/debounce, pulse N, await a one-hot light change.
// Optional request counter enabled by defining REQ_CNT_EN; otherwise req_cnt is tied to zero.
module change_req_gen #(
  parameter int unsigned UCY     = 1000,
  parameter int unsigned DEB     = 20,
  parameter int unsigned HOLDOFF = 3,
  parameter int unsigned TIMEOUT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       J,
  input  logic       P,
  input  logic       C,
  output logic       N,
  output logic       busy,
  output logic       err,
  output logic [7:0] req_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_REQ,
    S_WAIT_ACK,
    S_HOLDOFF
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sync1;
  logic        r_btn_s;
  logic        r_armed;
  logic [7:0]  r_deb_cnt;
  logic [11:0] r_tick;
  logic [3:0]  r_sec;
  logic [2:0]  r_snap;
  logic        r_n;
  logic        r_err;
  logic [2:0]  w_lights;
  logic        w_onehot;
  logic        w_ack;
  logic        w_tick_wrap;
  logic        w_timeout;
  logic        w_hold_done;

  assign w_lights    = {J, P, C};
  assign w_onehot    = (w_lights == 3'b100) || (w_lights == 3'b010) || (w_lights == 3'b001);
  assign w_ack       = w_onehot && (w_lights != r_snap);
  assign w_tick_wrap = (r_tick == 12'(UCY - 1));
  assign w_timeout   = w_tick_wrap && (r_sec == 4'(TIMEOUT - 1));
  assign w_hold_done = w_tick_wrap && (r_sec == 4'(HOLDOFF - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (r_btn_s && r_armed) w_next = S_DEBOUNCE;
      S_DEBOUNCE: begin
        if (!r_btn_s)                      w_next = S_IDLE;
        else if (r_deb_cnt == 8'(DEB))     w_next = S_REQ;
      end
      S_REQ:      w_next = S_WAIT_ACK;
      S_WAIT_ACK: if (w_ack || w_timeout) w_next = S_HOLDOFF;
      S_HOLDOFF:  if (w_hold_done)        w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_armed <= 1'b1;
      r_deb_cnt <= '0;
      r_tick  <= '0;
      r_sec   <= '0;
      r_snap  <= '0;
      r_n     <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sync1 <= btn;
      r_btn_s <= r_sync1;
      if (!r_btn_s)
        r_armed <= 1'b1;
      else if (r_state == S_DEBOUNCE && w_next == S_REQ)
        r_armed <= 1'b0;
      // Reloading 1 every IDLE cycle is equivalent to loading it on DEBOUNCE entry.
      if (r_state == S_IDLE)
        r_deb_cnt <= 8'd1;
      else if (r_state == S_DEBOUNCE)
        r_deb_cnt <= r_deb_cnt + 8'd1;
      r_n <= (w_next == S_REQ);
      if (r_state == S_REQ)
        r_snap <= w_lights;
      // Tick/second counters are shared: ack timeout in WAIT_ACK, hold-off in HOLDOFF.
      if (r_state == S_REQ || (r_state == S_WAIT_ACK && w_next == S_HOLDOFF)) begin
        r_tick <= '0;
        r_sec  <= '0;
      end else if (r_state == S_WAIT_ACK || r_state == S_HOLDOFF) begin
        if (w_tick_wrap) begin
          r_tick <= '0;
          r_sec  <= r_sec + 4'd1;
        end else begin
          r_tick <= r_tick + 12'd1;
        end
      end
      if (r_state == S_WAIT_ACK && w_timeout && !w_ack)
        r_err <= 1'b1;
    end
  end

`ifdef REQ_CNT_EN
  logic [7:0] r_req_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_req_cnt <= '0;
    else if (r_state == S_WAIT_ACK && w_ack && r_req_cnt != 8'hFF)
      r_req_cnt <= r_req_cnt + 8'd1;
  end

  assign req_cnt = r_req_cnt;
`else
  assign req_cnt = '0;
`endif

  assign N    = r_n;
  assign err  = r_err;
  assign busy = (r_state == S_REQ) || (r_state == S_WAIT_ACK) || (r_state == S_HOLDOFF);

endmodule

// File: tb/tb_change_req_gen.sv
// Self-checking bench for change_req_gen with randomized press/ack timing against a transaction-level model.
module tb_change_req_gen;

  localparam int UCY = 10;
  localparam int DEB = 4;
  localparam int HOLDOFF = 2;
  localparam int TIMEOUT = 3;
`ifdef REQ_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       btn;
  logic       N;
  logic       busy;
  logic       err;
  logic [7:0] req_cnt;
  logic [2:0] lights;
  logic [2:0] cur;

  int checks = 0;
  int failures = 0;
  int n_total = 0;
  logic prev_n = 1'b0;
  int exp_req = 0;
  logic exp_err = 1'b0;

  change_req_gen #(.UCY(UCY), .DEB(DEB), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .J(lights[2]), .P(lights[1]), .C(lights[0]),
    .N(N), .busy(busy), .err(err), .req_cnt(req_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // N pulse counter and single-cycle rule, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (N === 1'b1) begin
        n_total++;
        checks++;
        if (prev_n === 1'b1) begin
          failures++;
          $display("FAIL n_consecutive got=1 exp=0 at %0t", $time);
        end
      end
      prev_n = N;
    end else begin
      prev_n = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt();
    return CNT_EN ? exp_req : 0;
  endfunction

  function automatic logic [2:0] other_onehot(input logic [2:0] c);
    logic [2:0] cand;
    do begin
      case ($urandom_range(0, 2))
        0: cand = 3'b100;
        1: cand = 3'b010;
        default: cand = 3'b001;
      endcase
    end while (cand == c);
    return cand;
  endfunction

  // One full request from IDLE: press, N latency, ack (optionally glitched) or timeout, hold-off length.
  task automatic run_request(input int ack_d, input bit do_ack, input bit glitch,
                             input bit keep_btn, input string tag);
    int n0;
    int cnt;
    n0 = n_total;
    btn = 1'b1;
    cnt = 0;
    do begin tick(); cnt++; end while (N !== 1'b1 && cnt < 60);
    checks++;
    if (cnt != DEB + 3) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", tag, cnt, DEB + 3);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_with_n got=%b exp=1", tag, busy);
    end
    if (!keep_btn) btn = 1'b0;
    tick();
    checks++;
    if (N !== 1'b0) begin
      failures++;
      $display("FAIL %s_n_width got=%b exp=0", tag, N);
    end
    if (do_ack) begin
      for (int d = 0; d < ack_d; d++) begin
        if (glitch && d == ack_d - 2) lights = 3'b000;
        if (glitch && d == ack_d - 1) lights = ~cur;
        tick();
      end
      cur = other_onehot(cur);
      lights = cur;
      tick();
      if (exp_req < 255) exp_req++;
      checks++;
      if (int'(req_cnt) != exp_cnt()) begin
        failures++;
        $display("FAIL %s_req_cnt got=%0d exp=%0d", tag, req_cnt, exp_cnt());
      end
      checks++;
      if (err !== exp_err) begin
        failures++;
        $display("FAIL %s_err_after_ack got=%b exp=%b", tag, err, exp_err);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin tick(); cnt++; end
      checks++;
      if (cnt != HOLDOFF * UCY) begin
        failures++;
        $display("FAIL %s_holdoff_len got=%0d exp=%0d", tag, cnt, HOLDOFF * UCY);
      end
    end else begin
      if (!exp_err) begin
        cnt = 0;
        while (err !== 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++;
        if (cnt != TIMEOUT * UCY) begin
          failures++;
          $display("FAIL %s_timeout_len got=%0d exp=%0d", tag, cnt, TIMEOUT * UCY);
        end
        exp_err = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin tick(); cnt++; end
        checks++;
        if (cnt != HOLDOFF * UCY) begin
          failures++;
          $display("FAIL %s_holdoff_len got=%0d exp=%0d", tag, cnt, HOLDOFF * UCY);
        end
      end else begin
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin tick(); cnt++; end
        checks++;
        if (cnt != (TIMEOUT + HOLDOFF) * UCY) begin
          failures++;
          $display("FAIL %s_busy_len got=%0d exp=%0d", tag, cnt, (TIMEOUT + HOLDOFF) * UCY);
        end
      end
    end
    checks++;
    if (err !== exp_err) begin
      failures++;
      $display("FAIL %s_err_end got=%b exp=%b", tag, err, exp_err);
    end
    checks++;
    if (n_total - n0 != 1) begin
      failures++;
      $display("FAIL %s_n_count got=%0d exp=1", tag, n_total - n0);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({N, busy, err} !== 3'b000 || req_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b/%0d exp=000/0", N, busy, err, req_cnt);
    end
    rst = 1'b1;
    repeat (5) tick();
  endtask

  task automatic bounce_pulse(input int len, input int gap);
    btn = 1'b1;
    repeat (len) tick();
    btn = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_bounce();
    int n0;
    n0 = n_total;
    bounce_pulse(3, 1);
    bounce_pulse(2, 1);
    for (int i = 0; i < 6; i++) bounce_pulse($urandom_range(1, DEB), $urandom_range(1, 3));
    repeat (10) tick();
    checks++;
    if (n_total != n0) begin
      failures++;
      $display("FAIL bounce_no_n got=%0d exp=0", n_total - n0);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bounce_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_clean_ack();
    run_request(5, 1'b1, 1'b0, 1'b0, "clean");
  endtask

  task automatic test_final_cycle_ack();
    run_request(TIMEOUT * UCY - 1, 1'b1, 1'b0, 1'b0, "final_ack");
  endtask

  task automatic test_glitch();
    run_request($urandom_range(2, TIMEOUT * UCY - 1), 1'b1, 1'b1, 1'b0, "glitch");
  endtask

  task automatic test_held_button();
    int n0;
    run_request(3, 1'b1, 1'b0, 1'b1, "held");
    n0 = n_total;
    repeat (20) tick();
    checks++;
    if (n_total != n0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL held_no_repeat got=%0d/%b exp=0/0", n_total - n0, busy);
    end
    btn = 1'b0;
    repeat (3) tick();
    run_request(7, 1'b1, 1'b0, 1'b0, "held2");
  endtask

  task automatic test_timeout();
    run_request(0, 1'b0, 1'b0, 1'b0, "timeout");
  endtask

  task automatic test_mid_reset();
    int n0;
    btn = 1'b1;
    repeat (DEB + 5) tick();
    btn = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({N, busy, err} !== 3'b000 || req_cnt !== 8'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b%b%b/%0d exp=000/0", N, busy, err, req_cnt);
    end
    exp_req = 0;
    exp_err = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    n0 = n_total;
    repeat (30) tick();
    checks++;
    if (n_total != n0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet got=%0d/%b/%b exp=0/0/0", n_total - n0, busy, err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) bounce_pulse($urandom_range(1, DEB), 2);
      if ($urandom_range(0, 3) == 0)
        run_request(0, 1'b0, 1'b0, 1'b0, "rand_to");
      else
        run_request($urandom_range(2, TIMEOUT * UCY - 1), 1'b1, $urandom_range(0, 1) == 1,
                    1'b0, "rand_ack");
      repeat ($urandom_range(1, 4)) tick();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 258; i++) run_request(0, 1'b1, 1'b0, 1'b0, "sat");
    checks++;
    if (int'(req_cnt) != (CNT_EN ? 255 : 0)) begin
      failures++;
      $display("FAIL sat_final got=%0d exp=%0d", req_cnt, CNT_EN ? 255 : 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    btn = 1'b0;
    lights = 3'b100;
    cur = 3'b100;
    test_reset();
    test_bounce();
    test_clean_ack();
    test_final_cycle_ack();
    test_glitch();
    test_held_button();
    test_timeout();
    test_mid_reset();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
